serial_sub: RTL and testbench



---
 rtl/serial_sub_pkg.sv | 9 +
 rtl/serial_sub_restcomp.sv | 13 +
 rtl/serial_sub.sv | 88 ++++++++
 tb/tb_serial_sub.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: state encodings and counter sizing shared by the serial subtractor
package serial_sub_pkg;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction
endpackage

// File: rtl/serial_sub_restcomp.sv
// restcomp: combinational full-subtractor cell (one bit of x - y - b)
module restcomp
  import serial_sub_pkg::*;
(
  input  logic xi,
  input  logic yi,
  input  logic bi,
  output logic Di,
  output logic Bo
);
  assign Di = xi ^ yi ^ bi;
  assign Bo = (~xi & yi) | (~(xi ^ yi) & bi);
endmodule

// File: rtl/serial_sub.sv
// serial_sub: LSB-first bit-serial subtractor with valid/ready handshake; SERIAL_SUB_OVF_EN adds signed overflow output ovf
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bo
`ifdef SERIAL_SUB_OVF_EN
  ,output logic            ovf
`endif
);
  localparam int CW = cnt_w(WIDTH);
  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_x, r_y, r_dsh, r_d;
  logic [CW-1:0]    r_cnt;
  logic             r_b, r_bo;
  logic             w_di, w_bo, w_last;
  logic [WIDTH-1:0] w_dnext;
  restcomp u_cell (.xi(r_x[0]), .yi(r_y[0]), .bi(r_b), .Di(w_di), .Bo(w_bo));
  assign w_last    = (r_state == SHIFT) && (r_cnt == CW'(WIDTH - 1));
  assign w_dnext   = {w_di, r_dsh[WIDTH-1:1]};
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign d         = r_d;
  assign bo        = r_bo;
  // r_dsh is the working shifter; r_d only updates on completion so d never shows partial results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_dsh   <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      r_b     <= 1'b0;
      r_bo    <= 1'b0;
    end else if (r_state == IDLE) begin
      if (in_valid) begin
        r_x     <= x;
        r_y     <= y;
        r_b     <= bin;
        r_cnt   <= '0;
        r_state <= SHIFT;
      end
    end else if (r_state == SHIFT) begin
      r_x   <= r_x >> 1;
      r_y   <= r_y >> 1;
      r_dsh <= w_dnext;
      r_b   <= w_bo;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_d     <= w_dnext;
        r_bo    <= w_bo;
        r_state <= DONE;
      end
    end else if (r_state == DONE) begin
      if (out_ready) r_state <= IDLE;
    end else begin
      r_state <= IDLE;
    end
  end
`ifdef SERIAL_SUB_OVF_EN
  logic r_xm, r_ym, r_ovf;
  assign ovf = r_ovf;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_xm  <= 1'b0;
      r_ym  <= 1'b0;
      r_ovf <= 1'b0;
    end else if (in_ready && in_valid) begin
      r_xm <= x[WIDTH-1];
      r_ym <= y[WIDTH-1];
    end else if (w_last) begin
      r_ovf <= (r_xm != r_ym) && (w_di != r_xm);
    end
  end
`endif
endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: randomized self-checking bench comparing serial_sub against plain-arithmetic subtraction
module tb_serial_sub;
  localparam int W = 8;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] d;
  logic         bo;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif
  int n_cmp = 0;
  int n_bad = 0;

  serial_sub #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .bo(bo)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_d(input int a, input int b, input int c);
    int r;
    r = a - b - c;
    return W'(r + 256);
  endfunction

  function automatic logic ref_bo(input int a, input int b, input int c);
    return a < b + c;
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int r;
    r = int'($signed(a)) - int'($signed(b)) - int'(c);
    return (r > 127) || (r < -128);
  endfunction

  // Launches one operation and returns the number of edges from accept to out_valid
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input bit noise, output int lat);
    int g;
    g = 0;
    while (!in_ready && g < 100) begin @(negedge clk); g++; end
    in_valid = 1'b1; x = a; y = b; bin = c;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      if (noise) begin
        in_valid = 1'($urandom); x = W'($urandom); y = W'($urandom);
        bin = 1'($urandom); out_ready = 1'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic check_result(input string name, input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input int lat);
    logic [W-1:0] ed;
    logic         eb;
    ed = ref_d(int'(a), int'(b), int'(c));
    eb = ref_bo(int'(a), int'(b), int'(c));
    n_cmp++;
    if (lat !== W) begin n_bad++; $display("FAIL %s latency got=%0d exp=%0d", name, lat, W); end
    n_cmp++;
    if (d !== ed) begin n_bad++; $display("FAIL %s d got=%h exp=%h (x=%h y=%h bin=%b)", name, d, ed, a, b, c); end
    n_cmp++;
    if (bo !== eb) begin n_bad++; $display("FAIL %s bo got=%b exp=%b (x=%h y=%h bin=%b)", name, bo, eb, a, b, c); end
`ifdef SERIAL_SUB_OVF_EN
    n_cmp++;
    if (ovf !== ref_ovf(a, b, c)) begin n_bad++; $display("FAIL %s ovf got=%b exp=%b", name, ovf, ref_ovf(a, b, c)); end
`endif
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL %s handshake out_valid=%b in_ready=%b exp 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, d, bo} !== {1'b1, 1'b0, {W{1'b0}}, 1'b0}) begin
      n_bad++; $display("FAIL reset in_ready=%b out_valid=%b d=%h bo=%b exp 1/0/00/0", in_ready, out_valid, d, bo);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat;
    run_op(8'h05, 8'h03, 1'b0, 1'b0, lat);
    check_result("basic_5_3", 8'h05, 8'h03, 1'b0, lat);
    n_cmp++;
    if (d !== 8'h02) begin n_bad++; $display("FAIL basic_const d got=%h exp=02", d); end
    handshake("basic");
  endtask

  task automatic test_borrow;
    int lat;
    run_op(8'h03, 8'h05, 1'b0, 1'b0, lat);
    check_result("borrow_3_5", 8'h03, 8'h05, 1'b0, lat);
    n_cmp++;
    if ({d, bo} !== {8'hFE, 1'b1}) begin n_bad++; $display("FAIL borrow_const d/bo got=%h/%b exp=fe/1", d, bo); end
    handshake("borrow1");
    run_op(8'h00, 8'h00, 1'b1, 1'b0, lat);
    check_result("borrow_eq_bin", 8'h00, 8'h00, 1'b1, lat);
    n_cmp++;
    if ({d, bo} !== {8'hFF, 1'b1}) begin n_bad++; $display("FAIL eq_bin_const d/bo got=%h/%b exp=ff/1", d, bo); end
    handshake("borrow2");
    run_op(8'h00, 8'hFF, 1'b1, 1'b0, lat);
    check_result("zero_minus_ones", 8'h00, 8'hFF, 1'b1, lat);
    n_cmp++;
    if ({d, bo} !== {8'h00, 1'b1}) begin n_bad++; $display("FAIL zero_ones_const d/bo got=%h/%b exp=00/1", d, bo); end
    handshake("borrow3");
  endtask

  task automatic test_ovf;
`ifdef SERIAL_SUB_OVF_EN
    int lat;
    run_op(8'h80, 8'h01, 1'b0, 1'b0, lat);
    check_result("ovf_80_01", 8'h80, 8'h01, 1'b0, lat);
    n_cmp++;
    if ({d, bo, ovf} !== {8'h7F, 1'b0, 1'b1}) begin n_bad++; $display("FAIL ovf_const got=%h/%b/%b exp=7f/0/1", d, bo, ovf); end
    handshake("ovf1");
    run_op(8'h10, 8'h01, 1'b0, 1'b0, lat);
    check_result("ovf_10_01", 8'h10, 8'h01, 1'b0, lat);
    n_cmp++;
    if (ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_none got=%b exp=0", ovf); end
    handshake("ovf2");
`endif
  endtask

  task automatic test_backpressure;
    int lat;
    run_op(8'h9C, 8'h27, 1'b1, 1'b0, lat);
    check_result("bp", 8'h9C, 8'h27, 1'b1, lat);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin in_valid = 1'b1; x = 8'h11; y = 8'h22; bin = 1'b0; end
      else in_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({out_valid, in_ready, d, bo} !== {1'b1, 1'b0, ref_d(8'h9C, 8'h27, 1), ref_bo(8'h9C, 8'h27, 1)}) begin
        n_bad++;
        $display("FAIL bp_hold cyc=%0d out_valid=%b in_ready=%b d=%h bo=%b exp 1/0/%h/%b", i, out_valid, in_ready, d, bo,
                 ref_d(8'h9C, 8'h27, 1), ref_bo(8'h9C, 8'h27, 1));
      end
    end
    in_valid = 1'b0;
    handshake("bp");
    run_op(8'h40, 8'h41, 1'b0, 1'b0, lat);
    check_result("bp_after", 8'h40, 8'h41, 1'b0, lat);
    handshake("bp_after");
  endtask

  task automatic test_reset_mid;
    int lat;
    int seen;
    in_valid = 1'b1; x = 8'hF0; y = 8'h0F; bin = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, d, bo, in_ready} !== {1'b0, {W{1'b0}}, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL rst_mid out_valid=%b d=%h bo=%b in_ready=%b exp 0/00/0/1", out_valid, d, bo, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin @(negedge clk); if (out_valid) seen++; end
    n_cmp++;
    if (seen !== 0) begin n_bad++; $display("FAIL rst_mid_ghost out_valid cycles got=%0d exp=0", seen); end
    run_op(8'hAA, 8'h55, 1'b0, 1'b0, lat);
    check_result("rst_after", 8'hAA, 8'h55, 1'b0, lat);
    n_cmp++;
    if ({d, bo} !== {8'h55, 1'b0}) begin n_bad++; $display("FAIL rst_after_const d/bo got=%h/%b exp=55/0", d, bo); end
    handshake("rst_after");
  endtask

  task automatic test_random;
    int lat;
    int stall;
    logic [W-1:0] a, b;
    logic c;
    for (int n = 0; n < 1000; n++) begin
      a = W'($urandom); b = W'($urandom); c = 1'($urandom);
      if (n % 50 == 0) begin a = b; end
      run_op(a, b, c, 1'b1, lat);
      check_result("random", a, b, c, lat);
      stall = $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        n_cmp++;
        if ({out_valid, d} !== {1'b1, ref_d(int'(a), int'(b), int'(c))}) begin
          n_bad++; $display("FAIL random_stall out_valid=%b d=%h exp 1/%h", out_valid, d, ref_d(int'(a), int'(b), int'(c)));
        end
      end
      handshake("random");
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_borrow;
    test_ovf;
    test_backpressure;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
